axi_rd_arbiter: RTL and testbench
=================================

// Module: axi_rd_arbiter
// PURPOSE
//  Shares the single AXI4 read-address/read-data channel of the CNN master between NUM_REQ burst
//  requesters (client 0 = IFM loader, client 1 = weight loader). Grants AR bursts round-robin,
//  tags each burst with ARID = client index, routes R beats back by RID and caps outstanding bursts.
//  Sits between the layer DMA clients and the AXI master port; OFM write path is untouched.
// PARAMETERS
//  ADDR_WIDTH      32   AXI address width
//  AXI_WIDTH       256  AXI data width
//  ID_WIDTH        4    AXI ID width; must satisfy NUM_REQ <= 2**ID_WIDTH
//  LEN_WIDTH       8    AXI burst length field width
//  NUM_REQ         2    number of read requesters
//  MAX_OUTSTANDING 4    max AR bursts issued but not yet completed by RLAST
// PORTS
//  ACLK           in  1                    clock
//  ARESETN        in  1                    reset, asynchronous, active-low
//  req_valid      in  NUM_REQ              client burst request
//  req_addr       in  NUM_REQ*ADDR_WIDTH   burst start address, client i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//  req_len        in  NUM_REQ*LEN_WIDTH    ARLEN value (beats-1), packed likewise
//  req_ready      out NUM_REQ              one-cycle grant pulse; payload captured that cycle
//  M_AXI_ARID/ARADDR/ARLEN/ARSIZE/ARBURST out  AR payload; ARSIZE=$clog2(AXI_WIDTH/8), ARBURST=INCR
//  M_AXI_ARVALID  out 1 / M_AXI_ARREADY in 1   AR handshake
//  M_AXI_RID in ID_WIDTH, M_AXI_RDATA in AXI_WIDTH, M_AXI_RRESP in 2, M_AXI_RLAST in 1, M_AXI_RVALID in 1
//  M_AXI_RREADY   out 1                    = cl_rready[RID] (1 for illegal RID)
//  cl_rdata       out AXI_WIDTH            M_AXI_RDATA passthrough (shared)
//  cl_rvalid      out NUM_REQ              one-hot RVALID decoded from RID
//  cl_rlast       out NUM_REQ              one-hot RLAST decoded from RID
//  cl_rready      in  NUM_REQ              client beat acceptance
//  outstanding    out $clog2(MAX_OUTSTANDING+1)  bursts in flight
//  rd_err         out 1                    sticky: RRESP!=OKAY or RID>=NUM_REQ seen
// BEHAVIOUR
//  - Reset: FSM=ARB, rr pointer=0, ARVALID=0, AR payload regs=0, req_ready=0, outstanding=0, rd_err=0.
//    Reset mid-burst abandons all in-flight state; no replay.
//  - FSM ARB: if outstanding<MAX_OUTSTANDING and any req_valid: pick winner, pulse req_ready[w],
//    register addr/len/ID=w, go ISSUE. Else stay. Requests held while outstanding==MAX.
//  - FSM ISSUE: ARVALID=1 from registers, payload stable; on ARREADY -> ARB. ARVALID-to-grant latency
//    1 cycle; back-to-back bursts every 2 cycles minimum.
//  - Round-robin: search starts at rr+1 (mod NUM_REQ); rr<=winner on grant. Single requester re-granted.
//  - Clients hold req_valid/addr/len stable until req_ready; deasserting early is legal (no grant).
//  - outstanding: +1 on AR handshake, -1 on R handshake with RLAST; both same cycle -> unchanged.
//    Never underflows: RLAST handshake at outstanding==0 sets rd_err, count stays 0.
//  - R routing combinational, zero latency. RID>=NUM_REQ: beat consumed (RREADY=1), no cl_rvalid, rd_err=1.
//  - Out-of-order returns across IDs accepted; ordering within an ID is slave responsibility.
//  - rd_err cleared only by reset.
// CONFIGURATION
//  AXI_RD_ARB_PRIO_EN defined: fixed priority, lowest index wins (IFM loader over weights); rr pointer
//    unused. Undefined (default): round-robin as above. AR/R behaviour otherwise identical.
// TESTING
//  1. Reset with req_valid=2'b11 -> all outputs 0; after release first grant req_ready=2'b01? no: rr=0 so
//     client 1 granted first, ARID=1; next grant client 0 (alternation 1,0,1,0 over 4 bursts).
//  2. Client0 addr=0x100 len=255, ARREADY held low 5 cycles -> ARVALID stays 1, ARADDR=0x100, ARLEN=255 stable.
//  3. Issue 4 bursts, no R data -> outstanding=4, 5th req_valid gets no req_ready until one RLAST beat.
//  4. AR handshake and RLAST handshake same cycle at outstanding=2 -> outstanding remains 2.
//  5. RID=1 beats with cl_rready[1]=0 -> RREADY=0, cl_rvalid=2'b10; RID=5 -> RREADY=1, rd_err=1 sticky.
//  6. AXI_RD_ARB_PRIO_EN defined, both requesting continuously -> client 0 granted every time.

Source files
------------

// File: rtl/axi_rd_arbiter.sv
// Read-channel arbiter: shares one AXI4 AR/R port between NUM_REQ burst clients, ARID = client index.
// Define AXI_RD_ARB_PRIO_EN for fixed priority (lowest index wins); default build is round-robin.
module axi_rd_arbiter #(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned AXI_WIDTH       = 256,
    parameter int unsigned ID_WIDTH        = 4,
    parameter int unsigned LEN_WIDTH       = 8,
    parameter int unsigned NUM_REQ         = 2,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                                   ACLK,
    input  logic                                   ARESETN,
    input  logic [NUM_REQ-1:0]                     req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]          req_addr,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]           req_len,
    output logic [NUM_REQ-1:0]                     req_ready,
    output logic [ID_WIDTH-1:0]                    M_AXI_ARID,
    output logic [ADDR_WIDTH-1:0]                  M_AXI_ARADDR,
    output logic [LEN_WIDTH-1:0]                   M_AXI_ARLEN,
    output logic [2:0]                             M_AXI_ARSIZE,
    output logic [1:0]                             M_AXI_ARBURST,
    output logic                                   M_AXI_ARVALID,
    input  logic                                   M_AXI_ARREADY,
    input  logic [ID_WIDTH-1:0]                    M_AXI_RID,
    input  logic [AXI_WIDTH-1:0]                   M_AXI_RDATA,
    input  logic [1:0]                             M_AXI_RRESP,
    input  logic                                   M_AXI_RLAST,
    input  logic                                   M_AXI_RVALID,
    output logic                                   M_AXI_RREADY,
    output logic [AXI_WIDTH-1:0]                   cl_rdata,
    output logic [NUM_REQ-1:0]                     cl_rvalid,
    output logic [NUM_REQ-1:0]                     cl_rlast,
    input  logic [NUM_REQ-1:0]                     cl_rready,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
    output logic                                   rd_err
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OUT_W-1:0]    OUT_MAX    = OUT_W'(MAX_OUTSTANDING);
    localparam logic [ID_WIDTH:0]   NUM_REQ_ID = (ID_WIDTH + 1)'(NUM_REQ);

    typedef enum logic {ST_ARB, ST_ISSUE} state_t;

    state_t                 state;
    logic [NUM_REQ-1:0]     win_oh;
    logic [IDX_W-1:0]       win_idx;
    logic [ADDR_WIDTH-1:0]  win_addr;
    logic [LEN_WIDTH-1:0]   win_len;
    logic                   rid_ok;
    logic                   sel_ready;
    logic                   ar_hs;
    logic                   rlast_hs;
    logic                   r_bad;

    assign M_AXI_ARSIZE  = 3'($clog2(AXI_WIDTH / 8));
    assign M_AXI_ARBURST = 2'b01;

`ifdef AXI_RD_ARB_PRIO_EN
    // Lowest requesting index wins; loop runs high-to-low so the last hit is the lowest.
    always_comb begin
        win_oh = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                win_oh    = '0;
                win_oh[i] = 1'b1;
            end
        end
    end
`else
    logic [IDX_W-1:0] rr_q;
    logic [IDX_W-1:0] cand;

    // Search from rr+1 onward; descending distance so the nearest requester after rr wins.
    always_comb begin
        win_oh = '0;
        cand   = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = IDX_W'((int'(rr_q) + k) % NUM_REQ);
            if (req_valid[cand]) begin
                win_oh       = '0;
                win_oh[cand] = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        win_idx  = '0;
        win_addr = '0;
        win_len  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_oh[i]) begin
                win_idx  = IDX_W'(i);
                win_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                win_len  = req_len[i*LEN_WIDTH +: LEN_WIDTH];
            end
        end
    end

    // Grant/issue FSM: grant captures the payload, ISSUE holds ARVALID until ARREADY.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state         <= ST_ARB;
            req_ready     <= '0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_ARID    <= '0;
            M_AXI_ARADDR  <= '0;
            M_AXI_ARLEN   <= '0;
`ifndef AXI_RD_ARB_PRIO_EN
            rr_q          <= '0;
`endif
        end else begin
            req_ready <= '0;
            case (state)
                ST_ARB: begin
                    if ((outstanding < OUT_MAX) && (|win_oh)) begin
                        req_ready     <= win_oh;
                        M_AXI_ARVALID <= 1'b1;
                        M_AXI_ARID    <= ID_WIDTH'(win_idx);
                        M_AXI_ARADDR  <= win_addr;
                        M_AXI_ARLEN   <= win_len;
`ifndef AXI_RD_ARB_PRIO_EN
                        rr_q          <= win_idx;
`endif
                        state         <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (M_AXI_ARREADY) begin
                        M_AXI_ARVALID <= 1'b0;
                        state         <= ST_ARB;
                    end
                end
                default: state <= ST_ARB;
            endcase
        end
    end

    // Zero-latency R routing; beats with an unknown RID are drained so the bus never stalls.
    always_comb begin
        rid_ok    = {1'b0, M_AXI_RID} < NUM_REQ_ID;
        cl_rvalid = '0;
        cl_rlast  = '0;
        sel_ready = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (M_AXI_RID == ID_WIDTH'(i)) begin
                cl_rvalid[i] = M_AXI_RVALID;
                cl_rlast[i]  = M_AXI_RVALID & M_AXI_RLAST;
                sel_ready    = cl_rready[i];
            end
        end
        M_AXI_RREADY = rid_ok ? sel_ready : 1'b1;
    end

    assign cl_rdata = M_AXI_RDATA;

    assign ar_hs    = M_AXI_ARVALID & M_AXI_ARREADY;
    assign rlast_hs = M_AXI_RVALID & M_AXI_RREADY & M_AXI_RLAST;
    assign r_bad    = M_AXI_RVALID & ((M_AXI_RRESP != 2'b00) | ~rid_ok);

    // In-flight burst count, saturating at zero; stray RLAST or bad response flags rd_err.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            outstanding <= '0;
            rd_err      <= 1'b0;
        end else begin
            if (ar_hs && !rlast_hs) begin
                outstanding <= outstanding + OUT_W'(1);
            end else if (!ar_hs && rlast_hs && (outstanding != '0)) begin
                outstanding <= outstanding - OUT_W'(1);
            end
            if (r_bad || (rlast_hs && (outstanding == '0))) begin
                rd_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: transaction-level model checked every cycle plus directed literal checks.
module tb_axi_rd_arbiter;

    localparam int AW = 32;
    localparam int DW = 256;
    localparam int IW = 4;
    localparam int LW = 8;
    localparam int NR = 2;
    localparam int MO = 4;
    localparam int OW = 3;

    logic                ACLK;
    logic                ARESETN;
    logic [NR-1:0]       req_valid;
    logic [NR*AW-1:0]    req_addr;
    logic [NR*LW-1:0]    req_len;
    logic [NR-1:0]       req_ready;
    logic [IW-1:0]       M_AXI_ARID;
    logic [AW-1:0]       M_AXI_ARADDR;
    logic [LW-1:0]       M_AXI_ARLEN;
    logic [2:0]          M_AXI_ARSIZE;
    logic [1:0]          M_AXI_ARBURST;
    logic                M_AXI_ARVALID;
    logic                M_AXI_ARREADY;
    logic [IW-1:0]       M_AXI_RID;
    logic [DW-1:0]       M_AXI_RDATA;
    logic [1:0]          M_AXI_RRESP;
    logic                M_AXI_RLAST;
    logic                M_AXI_RVALID;
    logic                M_AXI_RREADY;
    logic [DW-1:0]       cl_rdata;
    logic [NR-1:0]       cl_rvalid;
    logic [NR-1:0]       cl_rlast;
    logic [NR-1:0]       cl_rready;
    logic [OW-1:0]       outstanding;
    logic                rd_err;

    axi_rd_arbiter #(
        .ADDR_WIDTH(AW), .AXI_WIDTH(DW), .ID_WIDTH(IW), .LEN_WIDTH(LW),
        .NUM_REQ(NR), .MAX_OUTSTANDING(MO)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len), .req_ready(req_ready),
        .M_AXI_ARID(M_AXI_ARID), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN),
        .M_AXI_ARSIZE(M_AXI_ARSIZE), .M_AXI_ARBURST(M_AXI_ARBURST),
        .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RID(M_AXI_RID), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RLAST(M_AXI_RLAST), .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY),
        .cl_rdata(cl_rdata), .cl_rvalid(cl_rvalid), .cl_rlast(cl_rlast), .cl_rready(cl_rready),
        .outstanding(outstanding), .rd_err(rd_err)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int total = 0;
    int bad   = 0;
    int grants[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit            m_issue;
    logic [IW-1:0] m_id;
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_len;
    int            m_last;
    int            m_cnt;
    bit            m_err;
    logic [NR-1:0] m_ready;

    // Next client to be served given the current requests; -1 when nobody asks.
    function automatic int pick();
`ifdef AXI_RD_ARB_PRIO_EN
        for (int i = 0; i < NR; i++) if (req_valid[i]) return i;
`else
        for (int d = 1; d <= NR; d++) if (req_valid[(m_last + d) % NR]) return (m_last + d) % NR;
`endif
        return -1;
    endfunction

    function automatic bit exp_rready();
        if (int'(M_AXI_RID) >= NR) return 1'b1;
        return cl_rready[M_AXI_RID[0]];
    endfunction

    always @(posedge ACLK or negedge ARESETN) begin
        int w;
        bit ar_hs;
        bit rl;
        if (!ARESETN) begin
            m_issue <= 1'b0; m_id <= '0; m_addr <= '0; m_len <= '0;
            m_last <= 0; m_cnt <= 0; m_err <= 1'b0; m_ready <= '0;
        end else begin
            ar_hs = m_issue && M_AXI_ARREADY;
            rl    = M_AXI_RVALID && exp_rready() && M_AXI_RLAST;
            m_ready <= '0;
            if (m_issue) begin
                if (M_AXI_ARREADY) m_issue <= 1'b0;
            end else begin
                w = pick();
                if (w >= 0 && m_cnt < MO) begin
                    m_issue <= 1'b1;
                    m_ready <= NR'(1 << w);
                    m_id    <= IW'(w);
                    m_addr  <= req_addr[w*AW +: AW];
                    m_len   <= req_len[w*LW +: LW];
                    m_last  <= w;
                end
            end
            if (ar_hs && !rl) m_cnt <= m_cnt + 1;
            else if (rl && !ar_hs && m_cnt > 0) m_cnt <= m_cnt - 1;
            if (M_AXI_RVALID && (M_AXI_RRESP != 2'b00 || int'(M_AXI_RID) >= NR)) m_err <= 1'b1;
            if (rl && m_cnt == 0) m_err <= 1'b1;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge ACLK) begin
        logic [NR-1:0] ev;
        logic [NR-1:0] el;
        ev = '0;
        el = '0;
        for (int i = 0; i < NR; i++) begin
            if (M_AXI_RVALID && int'(M_AXI_RID) == i) begin
                ev[i] = 1'b1;
                el[i] = M_AXI_RLAST;
            end
        end
        chk("m_req_ready", req_ready, m_ready);
        chk("m_arvalid", M_AXI_ARVALID, m_issue);
        if (m_issue) begin
            chk("m_arid", M_AXI_ARID, m_id);
            chk("m_araddr", M_AXI_ARADDR, m_addr);
            chk("m_arlen", M_AXI_ARLEN, m_len);
        end
        chk("m_outstanding", outstanding, m_cnt);
        chk("m_rd_err", rd_err, m_err);
        chk("m_rready", M_AXI_RREADY, exp_rready());
        chk("m_cl_rvalid", cl_rvalid, ev);
        chk("m_cl_rlast", cl_rlast, el);
        total++;
        if (cl_rdata !== M_AXI_RDATA) begin
            bad++;
            $display("FAIL m_cl_rdata actual=%0h required=%0h", cl_rdata, M_AXI_RDATA);
        end
    end

    always @(posedge ACLK) begin
        if (ARESETN && M_AXI_ARVALID && M_AXI_ARREADY) grants.push_back(int'(M_AXI_ARID));
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic clear_inputs();
        req_valid = '0; M_AXI_ARREADY = 1'b0;
        M_AXI_RID = '0; M_AXI_RRESP = 2'b00; M_AXI_RLAST = 1'b0; M_AXI_RVALID = 1'b0;
        cl_rready = '0;
    endtask

    task automatic do_reset();
        ARESETN = 1'b0;
        clear_inputs();
        tick(); tick();
        ARESETN = 1'b1;
        grants.delete();
        tick();
    endtask

    task automatic wait_arvalid();
        int n = 0;
        while (!M_AXI_ARVALID && n < 20) begin
            tick();
            n++;
        end
        chk("arvalid_timeout", M_AXI_ARVALID, 1'b1);
    endtask

    task automatic r_beat(input int id, input bit last, input logic [NR-1:0] rdy);
        M_AXI_RID = IW'(id); M_AXI_RLAST = last; M_AXI_RVALID = 1'b1; cl_rready = rdy;
        M_AXI_RDATA = {8{$urandom()}};
        tick();
        M_AXI_RVALID = 1'b0; M_AXI_RLAST = 1'b0; cl_rready = '0;
    endtask

    initial begin
        int exp_first[4];
        int exp_fifth;
`ifdef AXI_RD_ARB_PRIO_EN
        exp_first = '{0, 0, 0, 0};
        exp_fifth = 0;
`else
        exp_first = '{1, 0, 1, 0};
        exp_fifth = 1;
`endif
        ARESETN = 1'b0;
        clear_inputs();
        M_AXI_RDATA = '0;
        req_valid = 2'b11;
        req_addr  = {32'h0000_2000, 32'h0000_1000};
        req_len   = {8'd7, 8'd3};
        tick(); tick(); tick();
        chk("rst_arvalid", M_AXI_ARVALID, 1'b0);
        chk("rst_req_ready", req_ready, 2'b00);
        chk("rst_araddr", M_AXI_ARADDR, 32'h0);
        chk("rst_arid_len", {M_AXI_ARID, M_AXI_ARLEN}, 12'h0);
        chk("rst_outstanding", outstanding, 3'd0);
        chk("rst_rd_err", rd_err, 1'b0);
        chk("arsize_arburst", {M_AXI_ARSIZE, M_AXI_ARBURST}, {3'd5, 2'b01});

        // Both clients request continuously; four bursts fill the window, then stall.
        M_AXI_ARREADY = 1'b1;
        ARESETN = 1'b1;
        repeat (20) tick();
        chk("grant_count_full", grants.size(), 4);
        for (int i = 0; i < 4 && i < grants.size(); i++) chk($sformatf("grant_order_%0d", i), grants[i], exp_first[i]);
        chk("outstanding_full", outstanding, 3'd4);
        chk("held_no_ready", req_ready, 2'b00);
        r_beat(0, 1'b1, 2'b11);
        repeat (6) tick();
        chk("grant_count_after_rlast", grants.size(), 5);
        if (grants.size() > 4) chk("grant_fifth", grants[4], exp_fifth);
        chk("outstanding_refill", outstanding, 3'd4);

        // Stalled ARREADY keeps the AR payload stable.
        do_reset();
        req_valid = 2'b01;
        req_addr  = {32'h0000_2000, 32'h0000_0100};
        req_len   = {8'd7, 8'd255};
        wait_arvalid();
        chk("stall_req_ready", req_ready, 2'b01);
        req_valid = 2'b00;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_arvalid", M_AXI_ARVALID, 1'b1);
            chk("stall_araddr", M_AXI_ARADDR, 32'h100);
            chk("stall_arlen_id", {M_AXI_ARID, M_AXI_ARLEN}, {4'd0, 8'd255});
        end
        M_AXI_ARREADY = 1'b1;
        tick();
        M_AXI_ARREADY = 1'b0;
        chk("stall_done_arvalid", M_AXI_ARVALID, 1'b0);
        chk("stall_done_out", outstanding, 3'd1);

        // Second burst from client 1, then AR and RLAST handshakes in the same cycle.
        req_valid = 2'b10;
        M_AXI_ARREADY = 1'b1;
        wait_arvalid();
        chk("c1_arid", M_AXI_ARID, 4'd1);
        req_valid = 2'b00;
        tick();
        chk("out_two", outstanding, 3'd2);
        M_AXI_ARREADY = 1'b0;
        req_valid = 2'b01;
        wait_arvalid();
        req_valid = 2'b00;
        M_AXI_ARREADY = 1'b1;
        r_beat(1, 1'b1, 2'b11);
        M_AXI_ARREADY = 1'b0;
        chk("same_cycle_out", outstanding, 3'd2);

        // R routing: backpressured legal ID, then an illegal ID that must be drained.
        M_AXI_RID = 4'd1; M_AXI_RVALID = 1'b1; cl_rready = 2'b01;
        #1;
        chk("rid1_rready", M_AXI_RREADY, 1'b0);
        chk("rid1_cl_rvalid", cl_rvalid, 2'b10);
        chk("rid1_no_err", rd_err, 1'b0);
        tick();
        M_AXI_RID = 4'd5;
        #1;
        chk("rid5_rready", M_AXI_RREADY, 1'b1);
        chk("rid5_cl_rvalid", cl_rvalid, 2'b00);
        tick();
        M_AXI_RVALID = 1'b0; cl_rready = '0;
        chk("rid5_err", rd_err, 1'b1);
        repeat (3) tick();
        chk("rid5_err_sticky", rd_err, 1'b1);
        chk("rid5_out_kept", outstanding, 3'd2);

        // Stray RLAST at zero outstanding, then an SLVERR response.
        do_reset();
        chk("rst2_rd_err", rd_err, 1'b0);
        r_beat(0, 1'b1, 2'b01);
        chk("underflow_err", rd_err, 1'b1);
        chk("underflow_out", outstanding, 3'd0);
        do_reset();
        M_AXI_RRESP = 2'b10;
        r_beat(1, 1'b0, 2'b10);
        M_AXI_RRESP = 2'b00;
        tick();
        chk("slverr_err", rd_err, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
